// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding,
// active levels of reset/enables and the all-zero word used by the sweep.
package regfile_mp_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic RST_ACTIVE = 1'b1;
    localparam logic EN_ACTIVE  = 1'b1;

    localparam int unsigned             MAX_DATA_W = 1024;
    localparam logic [MAX_DATA_W-1:0]   ZERO_WORD  = '0;

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-entry write select: for every non-zero entry, picks the highest-index
// enabled write port addressing it. Entry 0 has no select and is never written.
module regfile_wr_arb
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NWRITE = 2
) (
    input  logic [NWRITE-1:0]                       we_i,
    input  logic [NWRITE*ADDR_W-1:0]                waddr_i,
    input  logic [NWRITE*DATA_W-1:0]                wdata_i,
    output logic [2**ADDR_W-1:1]                    ent_we_o,
    output logic [2**ADDR_W-1:1][DATA_W-1:0]        ent_wd_o
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    // Ascending port scan: a later (higher-index) match overrides earlier ones.
    always_comb begin
        ent_we_o = '0;
        ent_wd_o = '0;
        for (int unsigned e = 1; e < DEPTH; e++) begin
            for (int unsigned k = 0; k < NWRITE; k++) begin
                if (we_i[k] == EN_ACTIVE && waddr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(e)) begin
                    ent_we_o[e] = 1'b1;
                    ent_wd_o[e] = wdata_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a zeroing sweep after reset or clr.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NWRITE-1:0]         we,
    input  logic [NWRITE*ADDR_W-1:0]  waddr,
    input  logic [NWRITE*DATA_W-1:0]  wdata,
    input  logic [NREAD-1:0]          re,
    input  logic [NREAD*ADDR_W-1:0]   raddr,
    output logic [NREAD*DATA_W-1:0]   rdata,
    input  logic                      clr,
    output logic                      init_busy
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [NWRITE-1:0]                 we_g;
    logic [DEPTH-1:1]                  ent_we;
    logic [DEPTH-1:1][DATA_W-1:0]      ent_wd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q <= ST_INIT;
            cnt_q   <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH-1)) state_d = ST_READY;
            end
            ST_READY: begin
                if (clr == EN_ACTIVE) begin
                    state_d = ST_INIT;
                    cnt_d   = ADDR_W'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign init_busy = (state_q == ST_INIT);
    assign we_g      = (state_q == ST_READY) ? we : '0;

    regfile_wr_arb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NWRITE (NWRITE)
    ) u_wr_arb (
        .we_i     (we_g),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .ent_we_o (ent_we),
        .ent_wd_o (ent_wd)
    );

    // Storage has no reset; the sweep is the only path that clears it.
    always_ff @(posedge clk) begin
        for (int unsigned e = 1; e < DEPTH; e++) begin
            if (state_q == ST_INIT && cnt_q == ADDR_W'(e)) begin
                mem_q[e] <= DATA_W'(ZERO_WORD);
            end else if (ent_we[e]) begin
                mem_q[e] <= ent_wd[e];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned j = 0; j < NREAD; j++) begin
            if (state_q == ST_READY && re[j] == EN_ACTIVE &&
                raddr[j*ADDR_W +: ADDR_W] != '0) begin
                rdata[j*DATA_W +: DATA_W] = mem_q[raddr[j*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
                for (int unsigned k = 0; k < NWRITE; k++) begin
                    if (we[k] == EN_ACTIVE &&
                        waddr[k*ADDR_W +: ADDR_W] == raddr[j*ADDR_W +: ADDR_W]) begin
                        rdata[j*DATA_W +: DATA_W] = wdata[k*DATA_W +: DATA_W];
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters, 2R/2W, depth 32).
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        init_busy;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        int          port;
        logic [31:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;

    regfile_mp #(
        .DATA_W (32),
        .ADDR_W (5),
        .NREAD  (2),
        .NWRITE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .clr       (clr),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic sb_read(input string name, input int port,
                           input logic [4:0] addr, input logic [31:0] exp);
        re[port] = 1'b1;
        raddr[port*5 +: 5] = addr;
        sbq.push_back('{name: name, port: port, exp: exp});
    endtask

    task automatic test_reset;
        int n;
        checks++;
        if (init_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy got %b want 1", init_busy);
        end
        sb_read("reset_rd0", 0, 5'd1, 32'h0);
        sb_read("reset_rd1", 1, 5'd31, 32'h0);
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n != 31) begin
            errors++;
            $display("FAIL reset_sweep_len got %0d want 31", n);
        end
        for (int a = 0; a < 32; a += 2) begin
            @(negedge clk);
            sb_read($sformatf("zero_addr%0d", a), 0, 5'(a), 32'h0);
            sb_read($sformatf("zero_addr%0d", a + 1), 1, 5'(a + 1), 32'h0);
            #1;
            while (sbq.size() > 0) begin
                sb_t e;
                e = sbq.pop_front();
                checks++;
                if (rdata[e.port*32 +: 32] !== e.exp) begin
                    errors++;
                    $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
                end
            end
            re = '0;
        end
    endtask

    task automatic test_priority;
        @(negedge clk);
        we = 2'b11;
        waddr = {5'd5, 5'd5};
        wdata = {32'h22, 32'h11};
        @(negedge clk);
        we = '0;
        sb_read("prio_addr5", 0, 5'd5, 32'h22);
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
    endtask

    task automatic test_addr0;
        @(negedge clk);
        we = 2'b01;
        waddr = {5'd0, 5'd0};
        wdata = {32'h0, 32'hDEADBEEF};
        sb_read("addr0_same", 0, 5'd0, 32'h0);
        sb_read("addr5_keep", 1, 5'd5, 32'h22);
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
        @(negedge clk);
        we = '0;
        sb_read("addr0_after", 0, 5'd0, 32'h0);
        raddr[9:5] = 5'd5;
        sbq.push_back('{name: "re_off", port: 1, exp: 32'h0});
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
    endtask

    task automatic test_bypass;
        @(negedge clk);
        we = 2'b01;
        waddr = {5'd0, 5'd7};
        wdata = {32'h0, 32'hA5};
        sb_read("byp_addr7", 0, 5'd7, BYP ? 32'hA5 : 32'h0);
        sb_read("byp_other", 1, 5'd5, 32'h22);
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
        @(negedge clk);
        we = 2'b11;
        waddr = {5'd9, 5'd9};
        wdata = {32'h2, 32'h1};
        sb_read("byp_prio9", 0, 5'd9, BYP ? 32'h2 : 32'h0);
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
        @(negedge clk);
        we = '0;
        sb_read("stored7", 0, 5'd7, 32'hA5);
        sb_read("stored9", 1, 5'd9, 32'h2);
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
    endtask

    task automatic test_clr;
        int n;
        @(negedge clk);
        we = 2'b01;
        waddr = {5'd0, 5'd3};
        wdata = {32'h0, 32'h1234};
        @(negedge clk);
        we = 2'b01;
        waddr = {5'd0, 5'd4};
        wdata = {32'h0, 32'hBEEF};
        clr = 1'b1;
        sb_read("pre_clr3", 0, 5'd3, 32'h1234);
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
        @(negedge clk);
        // Keep writing and holding clr throughout the sweep: both must be ignored.
        we = 2'b10;
        waddr = {5'd3, 5'd0};
        wdata = {32'hFFFF, 32'h0};
        sb_read("sweep_rd3", 0, 5'd3, 32'h0);
        sb_read("sweep_rd5", 1, 5'd5, 32'h0);
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        we = '0;
        clr = 1'b0;
        checks++;
        if (n != 31) begin
            errors++;
            $display("FAIL clr_sweep_len got %0d want 31", n);
        end
        @(negedge clk);
        sb_read("post_clr3", 0, 5'd3, 32'h0);
        sb_read("post_clr4", 1, 5'd4, 32'h0);
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
    endtask

    task automatic test_rst_mid_sweep;
        int n;
        @(negedge clk);
        we = 2'b01;
        waddr = {5'd0, 5'd20};
        wdata = {32'h0, 32'h55};
        @(negedge clk);
        we = '0;
        clr = 1'b1;
        sb_read("pre_rst20", 0, 5'd20, 32'h55);
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
        @(negedge clk);
        clr = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb_read("rst_rd20", 0, 5'd20, 32'h0);
        sb_read("rst_rd9", 1, 5'd9, 32'h0);
        #1;
        checks++;
        if (init_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy got %b want 1", init_busy);
        end
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n != 31) begin
            errors++;
            $display("FAIL rst_restart_len got %0d want 31", n);
        end
        @(negedge clk);
        sb_read("post_rst20", 0, 5'd20, 32'h0);
        sb_read("post_rst7", 1, 5'd7, 32'h0);
        #1;
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, rdata[e.port*32 +: 32], e.exp);
            end
        end
        re = '0;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        we = '0;
        waddr = '0;
        wdata = '0;
        re = '0;
        raddr = '0;
        #2;
        test_reset();
        test_priority();
        test_addr0();
        test_bypass();
        test_clr();
        test_rst_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
